// File: rtl/high_radix_divider_pkg.sv
// Shared types and default sizing for the radix-4 divider.
package hrd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DW_DEF = 32;
   localparam int VW_DEF = 16;
   localparam int ITER   = DW_DEF / 2;
   localparam int CNT_W  = $clog2(ITER);

endpackage

// File: rtl/high_radix_divider_if.sv
// Start/done handshake and operand/result bus of the radix-4 divider.
interface high_radix_divider_if
   import hrd_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
);
   logic          i_start;
   logic [DW-1:0] i_dividend;
   logic [VW-1:0] i_divisor;
   logic          o_busy;
   logic          o_done;
   logic [DW-1:0] o_quotient;
   logic [VW-1:0] o_remainder;
   logic          o_div_zero;

   modport master (
      output i_start, i_dividend, i_divisor,
      input  o_busy, o_done, o_quotient, o_remainder, o_div_zero
   );

   modport slave (
      input  i_start, i_dividend, i_divisor,
      output o_busy, o_done, o_quotient, o_remainder, o_div_zero
   );
endinterface

// File: rtl/high_radix_divider_r4_step.sv
// One radix-4 restoring step: picks the largest digit k with k*D <= P' and
// returns the reduced partial remainder.
module hrd_r4_step #(
   parameter int VW = 16
) (
   input  logic [VW+1:0] i_p,
   input  logic [VW-1:0] i_d,
   output logic [1:0]    o_k,
   output logic [VW-1:0] o_p
);
   logic [VW+1:0] w_d1;
   logic [VW+1:0] w_d2;
   logic [VW+1:0] w_d3;
   logic [VW+1:0] w_sub;

   assign w_d1 = {2'b00, i_d};
   assign w_d2 = {1'b0, i_d, 1'b0};
   assign w_d3 = w_d1 + w_d2;

   // Digit select; the result of P' - k*D is below D, so it fits VW bits.
   always_comb begin
      o_k   = 2'd0;
      w_sub = '0;
      if (i_p >= w_d3) begin
         o_k   = 2'd3;
         w_sub = w_d3;
      end else if (i_p >= w_d2) begin
         o_k   = 2'd2;
         w_sub = w_d2;
      end else if (i_p >= w_d1) begin
         o_k   = 2'd1;
         w_sub = w_d1;
      end else begin
         o_k   = 2'd0;
         w_sub = '0;
      end
      o_p = VW'(i_p - w_sub);
   end
endmodule

// File: rtl/high_radix_divider.sv
// Sequential radix-4 divider, 2 quotient bits per clock, start/done handshake.
// Define HRD_SIGNED_EN for two's-complement operands (truncating division).
module high_radix_divider
   import hrd_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input logic                clk,
   input logic                reset,
   high_radix_divider_if.slave bus
);
   localparam int ITER_L = DW / 2;
   localparam int CW     = (ITER_L > 1) ? $clog2(ITER_L) : 1;

   state_t        r_state;
   logic [DW-1:0] r_q;
   logic [VW-1:0] r_p;
   logic [VW-1:0] r_d;
   logic [CW-1:0] r_cnt;
   logic          r_dz;
   logic          r_busy;
   logic          r_done;
   logic          r_div_zero;
   logic [DW-1:0] r_quotient;
   logic [VW-1:0] r_remainder;
`ifdef HRD_SIGNED_EN
   logic          r_neg_q;
   logic          r_neg_r;
`endif

   logic [DW-1:0] w_dvd_mag;
   logic [VW-1:0] w_dvs_mag;
   logic [DW-1:0] w_q_res;
   logic [VW-1:0] w_r_res;
   logic [VW+1:0] w_p_shift;
   logic [1:0]    w_k;
   logic [VW-1:0] w_p_new;

   assign w_p_shift = {r_p, r_q[DW-1:DW-2]};

   hrd_r4_step #(.VW(VW)) u_step (
      .i_p (w_p_shift),
      .i_d (r_d),
      .o_k (w_k),
      .o_p (w_p_new)
   );

   // Operand magnitudes fed to the unsigned core at accept.
   always_comb begin
      w_dvd_mag = bus.i_dividend;
      w_dvs_mag = bus.i_divisor;
`ifdef HRD_SIGNED_EN
      if (bus.i_dividend[DW-1]) w_dvd_mag = -bus.i_dividend;
      else                      w_dvd_mag = bus.i_dividend;
      if (bus.i_divisor[VW-1])  w_dvs_mag = -bus.i_divisor;
      else                      w_dvs_mag = bus.i_divisor;
`endif
   end

   // Final sign fixup: quotient negated on sign mismatch, remainder follows dividend.
   always_comb begin
      w_q_res = r_q;
      w_r_res = r_p;
`ifdef HRD_SIGNED_EN
      if (r_neg_q) w_q_res = -r_q;
      else         w_q_res = r_q;
      if (r_neg_r) w_r_res = -r_p;
      else         w_r_res = r_p;
`endif
   end

   // Control FSM with datapath shift registers and registered results.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_q         <= '0;
         r_p         <= '0;
         r_d         <= '0;
         r_cnt       <= '0;
         r_dz        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
`ifdef HRD_SIGNED_EN
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.i_start) begin
                  r_busy     <= 1'b1;
                  r_div_zero <= 1'b0;
                  r_p        <= '0;
                  r_d        <= w_dvs_mag;
                  r_cnt      <= CW'(ITER_L - 1);
`ifdef HRD_SIGNED_EN
                  r_neg_q    <= bus.i_dividend[DW-1] ^ bus.i_divisor[VW-1];
                  r_neg_r    <= bus.i_dividend[DW-1];
`endif
                  if (bus.i_divisor == '0) begin
                     // Raw dividend kept so its low bits can be returned as remainder.
                     r_dz    <= 1'b1;
                     r_q     <= bus.i_dividend;
                     r_state <= DONE;
                  end else begin
                     r_dz    <= 1'b0;
                     r_q     <= w_dvd_mag;
                     r_state <= RUN;
                  end
               end else begin
                  r_busy <= 1'b0;
               end
            end
            RUN: begin
               r_q <= {r_q[DW-3:0], w_k};
               r_p <= w_p_new;
               if (r_cnt == '0) begin
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               r_done     <= 1'b1;
               r_div_zero <= r_dz;
               if (r_dz) begin
                  r_quotient  <= '1;
                  r_remainder <= r_q[VW-1:0];
               end else begin
                  r_quotient  <= w_q_res;
                  r_remainder <= w_r_res;
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_div_zero  = r_div_zero;
   assign bus.o_quotient  = r_quotient;
   assign bus.o_remainder = r_remainder;
endmodule
